// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// Handles one operation at a time: grant, hold operands for EXEC_CYCLES, then present the response.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctrl,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctrl,
  input  logic [4:0]  req1_shamt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(EXEC_CYCLES - 1);

  state_t      state, next_state;
  logic        last_grant;
  logic        owner;
  logic        grant;
  logic        handshake;
  logic        exec_done;
  logic        ctrl_ok;
  logic [3:0]  count;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  always_comb begin
    ctrl_ok = 1'b0;
    case (alu_control)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0110, 4'b0111, 4'b1100: ctrl_ok = 1'b1;
      default:                   ctrl_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    handshake  = 1'b0;
    exec_done  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        handshake  = req0_ready || req1_ready;
        if (handshake) next_state = EXEC;
      end
      EXEC: begin
        exec_done = (count == LAST_COUNT);
        if (exec_done) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly, so they only change on a new grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      alu_shamt   <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      count       <= '0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      if (handshake) begin
        alu_a       <= grant ? req1_a     : req0_a;
        alu_b       <= grant ? req1_b     : req0_b;
        alu_control <= grant ? req1_ctrl  : req0_ctrl;
        alu_shamt   <= grant ? req1_shamt : req0_shamt;
        owner       <= grant;
        last_grant  <= grant;
        count       <= '0;
      end else if (exec_done) begin
        count <= '0;
      end else if (state == EXEC) begin
        count <= count + 4'd1;
      end

      // Unsupported codes report an error and mask whatever the ALU produced.
      if (exec_done) begin
        rsp_id     <= owner;
        rsp_result <= ctrl_ok ? alu_result : 32'd0;
        rsp_zero   <= ctrl_ok ? alu_zero : 1'b1;
        rsp_err    <= ~ctrl_ok;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int vectors = 0;
  int miscompares = 0;

  alu_arbiter #(.EXEC_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_shamt(req1_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared ALU; unknown codes return a marker value the arbiter must mask.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0011: alu_result = alu_b << alu_shamt;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] ctrl, input logic [4:0] shamt);
    if (id) begin
      req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_shamt = shamt; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_shamt = shamt; req0_valid = 1'b1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for the requester's ready, completes the handshake and drops valid.
  task automatic waitGrant(input bit id, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_grant"}, got, 1'b1);
    if (got) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    checkOutput({tag, "_valid"}, rsp_valid, 1'b1);
  endtask

  task automatic checkResp(input string tag, input logic id, input logic [31:0] result,
                           input logic zero, input logic err);
    checkOutput({tag, "_id"}, rsp_id, id);
    checkOutput({tag, "_result"}, rsp_result, result);
    checkOutput({tag, "_zero"}, rsp_zero, zero);
    checkOutput({tag, "_err"}, rsp_err, err);
  endtask

  task automatic waitResponse(input string tag, input logic id, input logic [31:0] result,
                              input logic zero, input logic err);
    waitValid(tag);
    checkResp(tag, id, result, zero, err);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    checkResp(tag, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput({tag, "_alu_a"}, alu_a, 32'd0);
    checkOutput({tag, "_alu_b"}, alu_b, 32'd0);
    checkOutput({tag, "_alu_control"}, alu_control, 4'd0);
    checkOutput({tag, "_alu_shamt"}, alu_shamt, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_shamt = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    // Single ADD with latency tracking
    applyStimulus(1'b0, 32'd4, 32'd1, 4'b0010, 5'd0);
    #1;
    checkOutput("add_req0_ready", req0_ready, 1'b1);
    checkOutput("add_req1_ready", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    checkOutput("add_exec_ctrl", alu_control, 4'b0010);
    checkOutput("add_exec_a", alu_a, 32'd4);
    checkOutput("add_exec_b", alu_b, 32'd1);
    checkOutput("add_exec_valid0", rsp_valid, 1'b0);
    @(negedge clk);
    checkOutput("add_exec_valid1", rsp_valid, 1'b0);
    checkOutput("add_exec_ctrl1", alu_control, 4'b0010);
    @(negedge clk);
    checkOutput("add_rsp_valid", rsp_valid, 1'b1);
    checkResp("add", 1'b0, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("add_consumed", rsp_valid, 1'b0);
    checkOutput("add_hold_a", alu_a, 32'd4);

    // Contention right after reset: req0 wins first
    doReset();
    applyStimulus(1'b0, 32'd4, 32'd4, 4'b0110, 5'd0);
    applyStimulus(1'b1, 32'd0, 32'd1, 4'b0011, 5'd3);
    #1;
    checkOutput("contend_req1_ready", req1_ready, 1'b0);
    waitGrant(1'b0, "contend0");
    waitValid("contend0");
    checkResp("contend0", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("contend_consume_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("contend_idle_req1_ready", req1_ready, 1'b1);
    waitGrant(1'b1, "contend1");
    waitResponse("contend1", 1'b1, 32'd8, 1'b0, 1'b0);

    // Both held valid: grants alternate starting with req0
    applyStimulus(1'b0, 32'h000000F0, 32'h0000003C, 4'b0000, 5'd0);
    applyStimulus(1'b1, 32'h000000F0, 32'h0000000F, 4'b0001, 5'd0);
    for (int i = 0; i < 6; i++) begin
      waitValid($sformatf("rr%0d", i));
      checkResp($sformatf("rr%0d", i), 1'(i % 2),
                (i % 2) ? 32'h000000FF : 32'h00000030, 1'b0, 1'b0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Unsupported control code
    applyStimulus(1'b1, 32'd5, 32'd7, 4'b1111, 5'd0);
    waitGrant(1'b1, "err");
    waitResponse("err", 1'b1, 32'd0, 1'b1, 1'b1);

    // Back-pressure on the response while req1 waits
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 4'b0111, 5'd0);
    waitGrant(1'b0, "slt");
    waitValid("slt");
    applyStimulus(1'b1, 32'd0, 32'd0, 4'b1100, 5'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("slt_hold%0d_valid", i), rsp_valid, 1'b1);
      checkOutput($sformatf("slt_hold%0d_result", i), rsp_result, 32'd1);
      checkOutput($sformatf("slt_hold%0d_zero", i), rsp_zero, 1'b0);
      checkOutput($sformatf("slt_hold%0d_alu_a", i), alu_a, 32'hFFFFFFFF);
      checkOutput($sformatf("slt_hold%0d_req0_ready", i), req0_ready, 1'b0);
      checkOutput($sformatf("slt_hold%0d_req1_ready", i), req1_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("slt_consume_req1_ready", req1_ready, 1'b0);
    waitGrant(1'b1, "nor");
    waitResponse("nor", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Reset one cycle into EXEC discards the operation
    applyStimulus(1'b0, 32'd7, 32'd8, 4'b0010, 5'd0);
    waitGrant(1'b0, "abort");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetValues("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_quiet%0d", i), rsp_valid, 1'b0);
    end
    applyStimulus(1'b1, 32'd10, 32'd3, 4'b0110, 5'd0);
    waitGrant(1'b1, "after_abort");
    waitResponse("after_abort", 1'b1, 32'd7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 2, SHALL set the number of cycles operands are held on the ALU before the result is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-007 reqN_ctrl  input  4  ALU control code of requester N.
REQ-008 reqN_shamt  input  5  shift amount of requester N.
REQ-009 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-010 alu_control  output  4  control code driven to the ALU.
REQ-011 alu_shamt  output  5  shift amount driven to the ALU.
REQ-012 alu_result  input  32  ALU result; alu_zero  input  1  ALU zero flag.
REQ-013 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  index of requester owning the response.
REQ-015 rsp_result  output  32; rsp_zero  output  1; rsp_err  output  1  unsupported control code.

Function
REQ-016 The block SHALL implement states IDLE, EXEC, RESP, one transaction in flight at a time.
REQ-017 IDLE: grant SHALL be computed combinationally; reqN_ready SHALL be high only in IDLE, for the granted requester, and only when reqN_valid is high.
REQ-018 Arbitration SHALL be round-robin: one valid -> that one; both valid -> requester != last_grant.
REQ-019 On handshake (valid & ready) the block SHALL register a, b, ctrl, shamt and the requester id, update last_grant, and enter EXEC.
REQ-020 EXEC: alu_a/alu_b/alu_control/alu_shamt SHALL come from the operand registers and stay stable; a cycle counter SHALL count EXEC_CYCLES cycles.
REQ-021 On the final EXEC cycle edge the block SHALL capture alu_result and alu_zero into rsp_result/rsp_zero and enter RESP.
REQ-022 Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0110 SUB, 0111 SLT, 1100 NOR; any other code SHALL yield rsp_err=1, rsp_result=0, rsp_zero=1 (ALU output ignored).
REQ-023 RESP: rsp_valid SHALL be high; rsp_id/rsp_result/rsp_zero/rsp_err SHALL be stable until rsp_valid & rsp_ready, then the block SHALL return to IDLE.
REQ-024 No new request SHALL be accepted in the cycle a response is consumed; acceptance earliest in the following IDLE cycle.
REQ-025 Latency: handshake at edge k -> rsp_valid high from edge k+EXEC_CYCLES onward; back-to-back throughput = one op per EXEC_CYCLES+2 cycles with rsp_ready held high.
REQ-026 Operand registers and ALU-facing outputs SHALL hold their last values in IDLE and RESP.
REQ-027 Request inputs changing while not granted SHALL have no effect; a requester dropping valid before handshake SHALL lose nothing.

Reset
REQ-028 On reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_a=alu_b=0, alu_control=0, alu_shamt=0, counter=0, last_grant=1 (requester 0 wins first contention).
REQ-029 Reset during EXEC or RESP SHALL discard the transaction with no response emitted.

Verification
REQ-030 req0 ADD a=4 b=1, EXEC_CYCLES=2 -> alu_control=0010 during EXEC, rsp_result=5, rsp_zero=0, rsp_id=0, rsp_valid at handshake edge+2.
REQ-031 req0 and req1 valid together after reset (req0 SUB 4-4, req1 SLL b=1 shamt=3) -> req0 served first: result 0, zero=1; then req1: result 8, rsp_id=1.
REQ-032 Both requesters held valid for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
REQ-033 req1 ctrl=1111 -> rsp_err=1, rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-034 rsp_ready low 5 cycles in RESP (SLT a=-1 b=1 -> result 1) -> rsp_valid and rsp_result=1 held stable, both reqN_ready low throughout.
REQ-035 reset asserted one cycle into EXEC -> next cycle all REQ-028 values, no rsp_valid; subsequent req1 request granted normally.
